// File: rtl/core_sw_pkg.sv
// Shared widths and FSM encoding for the NMI core switch.
package core_sw_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_HOLD  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/nmi_addr_remap.sv
// Combinational top-byte address remap; the lowest-indexed matching window wins.
module nmi_addr_remap
  import core_sw_pkg::*;
#(
  parameter int unsigned           REMAP_N    = 2,
  parameter logic [REMAP_N*8-1:0]  REMAP_FROM = {8'h30, 8'ha0},
  parameter logic [REMAP_N*8-1:0]  REMAP_TO   = {8'h00, 8'h40}
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Walk from the top index down so a lower-index match overrides.
  always_comb begin
    addr_o = addr_i;
    for (int i = int'(REMAP_N) - 1; i >= 0; i--) begin
      if (addr_i[31:24] == REMAP_FROM[i*8 +: 8]) begin
        addr_o = {REMAP_TO[i*8 +: 8], addr_i[23:0]};
      end
    end
  end

endmodule

// File: rtl/nmi_core_switch.sv
// N-core NMI front end: runtime core selection with drain/re-reset, IRQ gating,
// address remap and bus-timeout abort.
module nmi_core_switch
  import core_sw_pkg::*;
#(
  parameter int unsigned              N_CORE     = 2,
  parameter int unsigned              SEL_W      = (N_CORE > 1) ? $clog2(N_CORE) : 1,
  parameter int unsigned              DEF_CORE   = 0,
  parameter int unsigned              RST_DLY    = 16,
  parameter int unsigned              REMAP_N    = 2,
  parameter logic [REMAP_N*8-1:0]     REMAP_FROM = {8'h30, 8'ha0},
  parameter logic [REMAP_N*8-1:0]     REMAP_TO   = {8'h00, 8'h40},
  parameter int unsigned              TIMEOUT    = 1024,
  parameter logic [DATA_W-1:0]        TMO_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [SEL_W-1:0]           sel_i,
  input  logic [31:0]                irq_i,
  output logic [N_CORE-1:0]          core_rst_o,
  output logic [N_CORE*32-1:0]       core_irq_o,
  input  logic [N_CORE-1:0]          c_valid_i,
  input  logic [N_CORE*ADDR_W-1:0]   c_addr_i,
  input  logic [N_CORE*DATA_W-1:0]   c_wdata_i,
  input  logic [N_CORE*STRB_W-1:0]   c_wstrb_i,
  output logic [N_CORE-1:0]          c_ready_o,
  output logic [DATA_W-1:0]          c_rdata_o,
  output logic                       m_valid_o,
  output logic [ADDR_W-1:0]          m_addr_o,
  output logic [DATA_W-1:0]          m_wdata_o,
  output logic [STRB_W-1:0]          m_wstrb_o,
  input  logic [DATA_W-1:0]          m_rdata_i,
  input  logic                       m_ready_i,
  output logic [SEL_W-1:0]           active_o,
  output logic                       busy_o,
  output logic                       tmo_err_o
);

  localparam int unsigned CNT_W  = (RST_DLY > 0) ? $clog2(RST_DLY + 1) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               abort_q, abort_d;
  logic               inflight_q, inflight_d;
  logic               tmo_err_q, tmo_err_d;

  logic               act_valid;
  logic [ADDR_W-1:0]  act_addr;
  logic [DATA_W-1:0]  act_wdata;
  logic [STRB_W-1:0]  act_wstrb;
  logic               run_phase;
  logic               outstanding;
  logic               beat_done;
  logic               tmo_fire;
  logic               sel_ok;

  always_comb begin
    act_valid = 1'b0;
    act_addr  = '0;
    act_wdata = '0;
    act_wstrb = '0;
    for (int i = 0; i < int'(N_CORE); i++) begin
      if (active_q == SEL_W'(i)) begin
        act_valid = c_valid_i[i];
        act_addr  = c_addr_i[i*ADDR_W +: ADDR_W];
        act_wdata = c_wdata_i[i*DATA_W +: DATA_W];
        act_wstrb = c_wstrb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  nmi_addr_remap #(
    .REMAP_N    (REMAP_N),
    .REMAP_FROM (REMAP_FROM),
    .REMAP_TO   (REMAP_TO)
  ) u_remap (
    .addr_i (act_addr),
    .addr_o (m_addr_o)
  );

  assign run_phase = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // In DRAIN only a beat already on the bus may stay visible to the master.
  assign m_valid_o = run_phase & act_valid & ~abort_q & ((state_q == ST_RUN) | inflight_q);
  assign m_wdata_o = act_wdata;
  assign m_wstrb_o = act_wstrb;

  assign outstanding = m_valid_o & ~m_ready_i;
  assign beat_done   = m_valid_o & m_ready_i;
  assign tmo_fire    = outstanding && ((32'(tcnt_q) + 32'd1) == TIMEOUT);
  assign sel_ok      = (sel_i != active_q) && (32'(sel_i) < N_CORE);

  assign c_rdata_o = tmo_fire ? TMO_RDATA : m_rdata_i;
  assign active_o  = active_q;
  assign busy_o    = (state_q != ST_RUN);
  assign tmo_err_o = tmo_err_q;

  always_comb begin
    c_ready_o  = '0;
    core_rst_o = '1;
    core_irq_o = '0;
    for (int i = 0; i < int'(N_CORE); i++) begin
      if (run_phase && (active_q == SEL_W'(i))) begin
        c_ready_o[i]         = beat_done | tmo_fire;
        core_rst_o[i]        = 1'b0;
        core_irq_o[i*32 +: 32] = irq_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    tcnt_d     = (outstanding & ~tmo_fire) ? tcnt_q + TCNT_W'(1) : '0;
    abort_d    = tmo_fire ? 1'b1 : (abort_q & act_valid);
    inflight_d = outstanding & ~tmo_fire;
    tmo_err_d  = tmo_err_q | tmo_fire;

    unique case (state_q)
      ST_HOLD: begin
        abort_d    = 1'b0;
        inflight_d = 1'b0;
        if (sel_ok) begin
          active_d = sel_i;
          cnt_d    = '0;
        end else if (32'(cnt_q) == RST_DLY) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sel_ok) begin
          pending_d = sel_i;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sel_ok) pending_d = sel_i;
        if (!inflight_q || m_ready_i || tmo_fire) begin
          state_d  = ST_HOLD;
          active_d = pending_d;
          cnt_d    = '0;
          abort_d  = 1'b0;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HOLD;
      active_q   <= SEL_W'(DEF_CORE);
      pending_q  <= SEL_W'(DEF_CORE);
      cnt_q      <= '0;
      tcnt_q     <= '0;
      abort_q    <= 1'b0;
      inflight_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      abort_q    <= abort_d;
      inflight_q <= inflight_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

endmodule

// File: tb/tb_nmi_core_switch.sv
// Directed bench for nmi_core_switch: reset release, remap, switch drain, timeout, reset abort.
module tb_nmi_core_switch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  sel_i;
  logic [31:0] irq_i;
  logic [1:0]  core_rst_o;
  logic [63:0] core_irq_o;
  logic [1:0]  c_valid_i;
  logic [63:0] c_addr_i;
  logic [63:0] c_wdata_i;
  logic [7:0]  c_wstrb_i;
  logic [1:0]  c_ready_o;
  logic [31:0] c_rdata_o;
  logic        m_valid_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic [31:0] m_rdata_i;
  logic        m_ready_i;
  logic [1:0]  active_o;
  logic        busy_o;
  logic        tmo_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // SEL_W widened so an out-of-range select can be presented.
  nmi_core_switch #(
    .N_CORE  (2),
    .SEL_W   (2),
    .RST_DLY (16),
    .TIMEOUT (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sel_i      (sel_i),
    .irq_i      (irq_i),
    .core_rst_o (core_rst_o),
    .core_irq_o (core_irq_o),
    .c_valid_i  (c_valid_i),
    .c_addr_i   (c_addr_i),
    .c_wdata_i  (c_wdata_i),
    .c_wstrb_i  (c_wstrb_i),
    .c_ready_o  (c_ready_o),
    .c_rdata_o  (c_rdata_o),
    .m_valid_o  (m_valid_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_wstrb_o  (m_wstrb_o),
    .m_rdata_i  (m_rdata_i),
    .m_ready_i  (m_ready_i),
    .active_o   (active_o),
    .busy_o     (busy_o),
    .tmo_err_o  (tmo_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] exp_a);
    c_valid_i[0]   = 1'b1;
    c_addr_i[31:0] = a;
    m_ready_i      = 1'b1;
    m_rdata_i      = a ^ 32'h5a5a_5a5a;
    #1;
    chk({tag, "_addr"}, m_addr_o, exp_a);
    chk({tag, "_rdy"}, c_ready_o, 2'b01);
    chk({tag, "_rdata"}, c_rdata_o, a ^ 32'h5a5a_5a5a);
    tick();
    c_valid_i = '0;
    m_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rel;
    int          hit;
    logic        bad;
    logic [31:0] rd;
    logic [31:0] fire_addr;

    rst_i = 1'b1; sel_i = '0; irq_i = '0; c_valid_i = '0; c_addr_i = '0;
    c_wdata_i = '0; c_wstrb_i = '0; m_rdata_i = '0; m_ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_core_rst", core_rst_o, 2'b11);
    chk("rst_mvalid", m_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_active", active_o, 2'd0);
    chk("rst_tmo_err", tmo_err_o, 1'b0);
    chk("rst_irq", core_irq_o, 64'h0);
    chk("rst_cready", c_ready_o, 2'b00);

    // Release after reset, with core0 already requesting during HOLD.
    c_valid_i = 2'b01;
    c_addr_i[31:0] = 32'h2000_0000;
    rst_i = 1'b0;
    rel = 0; bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!core_rst_o[0]) begin
        rel = k;
        break;
      end
      if (m_valid_o) bad = 1'b1;
    end
    chk("release_cycles", rel, 17);
    chk("hold_mvalid", bad, 1'b0);
    chk("run_core_rst", core_rst_o, 2'b10);
    chk("run_busy", busy_o, 1'b0);
    chk("run_mvalid", m_valid_o, 1'b1);
    c_valid_i = '0;

    xfer("remap30", 32'h3000_0010, 32'h0000_0010);
    xfer("remapA0", 32'hA000_0004, 32'h4000_0004);
    xfer("remap_none", 32'h2000_0000, 32'h2000_0000);

    // Write beat: data and strobes pass through.
    c_valid_i[0] = 1'b1;
    c_addr_i[31:0] = 32'h1000_0008;
    c_wdata_i[31:0] = 32'hCAFE_F00D;
    c_wstrb_i[3:0] = 4'h3;
    #1;
    chk("wr_wdata", m_wdata_o, 32'hCAFE_F00D);
    chk("wr_wstrb", m_wstrb_o, 4'h3);
    chk("wr_noready", c_ready_o, 2'b00);
    m_ready_i = 1'b1;
    #1;
    chk("wr_ready", c_ready_o, 2'b01);
    tick();
    c_valid_i = '0; m_ready_i = 1'b0; c_wstrb_i = '0;

    irq_i = 32'h4;
    sel_i = 2'd3;
    tick();
    tick();
    #1;
    chk("sel3_active", active_o, 2'd0);
    chk("sel3_busy", busy_o, 1'b0);
    chk("irq_core0", core_irq_o, 64'h0000_0000_0000_0004);
    sel_i = 2'd0;

    // Switch 0->1 while core0 beat stalls for 5 cycles.
    c_valid_i[0] = 1'b1;
    c_addr_i[31:0] = 32'h2000_0000;
    sel_i = 2'd1;
    #1;
    chk("sw_mvalid_run", m_valid_o, 1'b1);
    tick();
    chk("drain_busy", busy_o, 1'b1);
    chk("drain_mvalid", m_valid_o, 1'b1);
    chk("drain_active", active_o, 2'd0);
    chk("drain_core_rst", core_rst_o, 2'b10);
    repeat (3) tick();
    chk("drain_stall_rdy", c_ready_o, 2'b00);
    m_ready_i = 1'b1;
    #1;
    chk("drain_done_rdy", c_ready_o, 2'b01);
    tick();
    c_valid_i = '0; m_ready_i = 1'b0;
    #1;
    chk("sw_active", active_o, 2'd1);
    chk("sw_core_rst", core_rst_o, 2'b11);
    chk("sw_mvalid", m_valid_o, 1'b0);
    rel = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!core_rst_o[1]) begin
        rel = k;
        break;
      end
    end
    chk("sw_release_cycles", rel, 17);
    chk("sw_run_core_rst", core_rst_o, 2'b01);
    chk("irq_core1", core_irq_o, 64'h0000_0004_0000_0000);

    // Timeout on core1 with the slave never responding.
    c_valid_i = 2'b10;
    c_addr_i[63:32] = 32'hA000_0100;
    m_ready_i = 1'b0;
    hit = 0; rd = '0; fire_addr = '0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (c_ready_o[1]) begin
        hit = k;
        rd = c_rdata_o;
        fire_addr = m_addr_o;
        break;
      end
      tick();
    end
    chk("tmo_cycle", hit, 8);
    chk("tmo_rdata", rd, 32'hDEAD_BEEF);
    chk("tmo_addr_core1", fire_addr, 32'h4000_0100);
    tick();
    chk("tmo_err_set", tmo_err_o, 1'b1);
    chk("abort_mvalid", m_valid_o, 1'b0);
    chk("abort_cready", c_ready_o, 2'b00);
    c_valid_i = '0;
    tick();
    c_valid_i = 2'b10;
    m_ready_i = 1'b1;
    m_rdata_i = 32'h0000_0055;
    #1;
    chk("post_abort_mvalid", m_valid_o, 1'b1);
    chk("post_abort_rdy", c_ready_o, 2'b10);
    chk("post_abort_rdata", c_rdata_o, 32'h0000_0055);
    tick();
    chk("tmo_err_sticky", tmo_err_o, 1'b1);
    c_valid_i = '0; m_ready_i = 1'b0;

    // Reset in the middle of a stalled write.
    c_valid_i = 2'b10;
    c_wstrb_i[7:4] = 4'hF;
    #1;
    chk("rw_mvalid_pre", m_valid_o, 1'b1);
    rst_i = 1'b1;
    tick();
    chk("rw_mvalid", m_valid_o, 1'b0);
    chk("rw_core_rst", core_rst_o, 2'b11);
    chk("rw_tmo_err", tmo_err_o, 1'b0);
    chk("rw_active", active_o, 2'd0);
    rst_i = 1'b0;
    m_ready_i = 1'b1;
    tick();
    #1;
    chk("rw_late_ready", c_ready_o, 2'b00);
    chk("rw_retarget", active_o, 2'd1);
    chk("rw_mvalid_hold", m_valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
